// File: rtl/mem_lsu.sv
// Memory load/store unit: issues one bus access per memop with a timeout and
// stalls the pipeline until the access completes.
module mem_lsu #(
  parameter int unsigned BUS_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] maddr_i,
  input  logic [31:0] mstore_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        bus_err_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i
);

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLbu = 4'd2;
  localparam logic [3:0] OpLh  = 4'd3;
  localparam logic [3:0] OpLhu = 4'd4;
  localparam logic [3:0] OpLw  = 4'd5;
  localparam logic [3:0] OpSb  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSw  = 4'd8;

  localparam logic [7:0] CntLast = 8'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] sdata_q;
  logic [31:0] load_q;

  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        misaligned, active, stall;
  logic [3:0]  be_d;
  logic [31:0] sdata_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_fmt;

  // Decode the memop into direction and access width.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (memop_i)
      OpLb, OpLbu: begin is_load  = 1'b1; is_byte = 1'b1; end
      OpLh, OpLhu: begin is_load  = 1'b1; is_half = 1'b1; end
      OpLw:        begin is_load  = 1'b1; is_word = 1'b1; end
      OpSb:        begin is_store = 1'b1; is_byte = 1'b1; end
      OpSh:        begin is_store = 1'b1; is_half = 1'b1; end
      OpSw:        begin is_store = 1'b1; is_word = 1'b1; end
      default:     ;
    endcase
    misaligned = (is_half & maddr_i[0]) | (is_word & (|maddr_i[1:0]));
    active     = (is_load | is_store) & ~misaligned;
  end

  // Big-endian byte enables and replicated store data for the access width.
  always_comb begin
    be_d    = 4'b0000;
    sdata_d = mstore_i;
    if (is_byte) begin
      be_d    = 4'b1000 >> maddr_i[1:0];
      sdata_d = {4{mstore_i[7:0]}};
    end else if (is_half) begin
      be_d    = maddr_i[1] ? 4'b0011 : 4'b1100;
      sdata_d = {2{mstore_i[15:0]}};
    end else if (is_word) begin
      be_d    = 4'b1111;
    end
  end

  // Select the addressed lane of the read data and extend it.
  always_comb begin
    case (maddr_i[1:0])
      2'b00:   lane_b = dbus_rdata_i[31:24];
      2'b01:   lane_b = dbus_rdata_i[23:16];
      2'b10:   lane_b = dbus_rdata_i[15:8];
      default: lane_b = dbus_rdata_i[7:0];
    endcase
    lane_h = maddr_i[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
    case (memop_i)
      OpLb:    load_fmt = {{24{lane_b[7]}}, lane_b};
      OpLbu:   load_fmt = {24'h0, lane_b};
      OpLh:    load_fmt = {{16{lane_h[15]}}, lane_h};
      OpLhu:   load_fmt = {16'h0, lane_h};
      default: load_fmt = dbus_rdata_i;
    endcase
  end

  // Next-state logic; an ack beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (active) begin
          stall   = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        stall = 1'b1;
        if (dbus_ack_i || cnt_q == CntLast) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, bus registers, timeout counter and captured load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'h0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      sdata_q <= 32'h0;
      load_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (active) begin
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= {maddr_i[31:2], 2'b00};
            be_q    <= be_d;
            sdata_q <= sdata_d;
            cnt_q   <= 8'h0;
            err_q   <= 1'b0;
          end
        end
        StBusy: begin
          if (dbus_ack_i) begin
            load_q <= load_fmt;
            req_q  <= 1'b0;
          end else if (cnt_q == CntLast) begin
            err_q <= 1'b1;
            req_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'h1;
          end
        end
        StDone: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Writeback and status outputs, forced quiet while in reset.
  always_comb begin
    stall_req_o = ~rst & stall;
    adel_o      = ~rst & (state_q == StIdle) & is_load & misaligned;
    ades_o      = ~rst & (state_q == StIdle) & is_store & misaligned;
    bus_err_o   = ~rst & (state_q == StDone) & err_q;
    wd_o        = rst ? 5'h0 : wd_i;
    wreg_o      = ~rst & wreg_i & ~(adel_o | ades_o | bus_err_o);
    if (rst)                                wdata_o = 32'h0;
    else if (state_q == StDone && is_load)  wdata_o = load_q;
    else                                    wdata_o = wdata_i;
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = sdata_q;

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have parameter BUS_TIMEOUT, default 64, the number of BUSY cycles without dbus_ack_i before the access is abandoned (legal range 2..255).
REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- wd_i  in  5  destination register from execute.
- wreg_i  in  1  write-enable from execute.
- wdata_i  in  32  execute result.
- memop_i  in  4  memory op: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 are treated as none.
- maddr_i  in  32  effective address.
- mstore_i  in  32  store source register value.
- wd_o  out  5  destination register to writeback.
- wreg_o  out  1  write-enable to writeback.
- wdata_o  out  32  writeback data.
- stall_req_o  out  1  freeze request to the pipeline.
- adel_o  out  1  load address misaligned.
- ades_o  out  1  store address misaligned.
- bus_err_o  out  1  access timed out.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  bus write.
- dbus_addr_o  out  32  word address, with bits [1:0] forced to 0.
- dbus_be_o  out  4  byte enables.
- dbus_wdata_o  out  32  store data.
- dbus_ack_i  in  1  one-cycle completion strobe.
- dbus_rdata_i  in  32  read data, valid with the ack.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-004 Upstream SHALL hold all *_i inputs stable while stall_req_o=1.
REQ-005 A memop is "active" when it is in 1..8 and aligned: halfwords need maddr_i[0]=0, words need maddr_i[1:0]=0, bytes are always aligned.
REQ-006 In IDLE with an active memop, stall_req_o SHALL be 1 combinationally, and the next state SHALL be BUSY.
REQ-007 On entry to BUSY, the block SHALL register the bus signals: dbus_addr_o, dbus_we_o (1 for ops 6-8), dbus_be_o and dbus_wdata_o.
REQ-008 In BUSY, dbus_req_o=1 and stall_req_o=1.
REQ-009 In BUSY, dbus_addr_o, dbus_we_o, dbus_be_o and dbus_wdata_o SHALL remain constant until the state is left.
REQ-010 BUSY SHALL go to DONE on a cycle with dbus_ack_i=1, and that cycle SHALL capture the formatted load result.
REQ-011 A timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without an ack.
REQ-012 When the timeout counter reaches BUS_TIMEOUT-1 with no ack, the state SHALL go to DONE with the error flag set.
REQ-013 An ack arriving in the same cycle as the timeout SHALL win: no error is flagged.
REQ-014 In DONE:
- stall_req_o=0 and dbus_req_o=0;
- the next state SHALL be IDLE unconditionally, so the pipeline advances on this edge and the same op is never reissued.
REQ-015 dbus_ack_i outside BUSY SHALL be ignored.
REQ-016 Byte lanes SHALL be big-endian: addr[1:0]=00 selects bits [31:24] and 11 selects bits [7:0].
REQ-017 Store byte enables and data SHALL be:
- SB: dbus_be_o = 1000>>addr[1:0], data = {4{mstore_i[7:0]}};
- SH: dbus_be_o = 1100 (addr[1]=0) or 0011 (addr[1]=1), data = {2{mstore_i[15:0]}};
- SW: dbus_be_o = 1111, data = mstore_i.
REQ-018 Loads SHALL drive dbus_be_o the same as the matching store width.
REQ-019 Load results SHALL be extended as follows:
- LB and LH sign-extend the selected lane;
- LBU and LHU zero-extend the selected lane;
- LW passes the word through.
REQ-020 wd_o SHALL equal wd_i in all states.
REQ-021 wreg_o SHALL equal wreg_i, except that it is forced to 0 whenever adel_o, ades_o or bus_err_o is 1.
REQ-022 wdata_o SHALL be the captured load result in DONE for ops 1-5, and wdata_i otherwise.
REQ-023 Misaligned accesses SHALL be handled combinationally in IDLE:
- a misaligned load asserts adel_o; a misaligned store asserts ades_o;
- no bus request is made and stall_req_o=0.
REQ-024 bus_err_o SHALL be 1 only in a DONE cycle entered via timeout.
REQ-025 With memop none, the block SHALL be a pure pass-through with zero added latency.
REQ-026 An aligned access SHALL stall for the number of bus wait cycles plus 2.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be:
- state=IDLE and timeout counter=0;
- dbus_req_o=0, dbus_we_o=0, dbus_be_o=0, dbus_addr_o=0, dbus_wdata_o=0;
- captured load result=0 and error flag=0.
REQ-028 While rst=1, wd_o=0, wreg_o=0, wdata_o=0, stall_req_o=0, adel_o=0 and ades_o=0.
REQ-029 A reset asserted in BUSY SHALL abandon the access, with dbus_req_o low from the next cycle and any late ack ignored.

Verification
REQ-030 The bench SHALL cover these directed scenarios, one per line:
- memop=0, wdata_i=0x12345678, wd_i=5, wreg_i=1 -> same-cycle wdata_o=0x12345678, wd_o=5, wreg_o=1, stall_req_o=0.
- LB at addr 0x103, rdata 0xAABBCC80, ack after 2 wait cycles -> dbus_be_o=0001; stall_req_o high 4 cycles; DONE wdata_o=0xFFFFFF80 (LBU gives 0x00000080).
- SH at addr 0x202, mstore_i=0x0000BEEF -> dbus_addr_o=0x200, be=0011, dbus_we_o=1, wdata=0xBEEFBEEF.
- LW at addr 0x101 -> adel_o=1, wreg_o=0, dbus_req_o never 1, no stall.
- LW with ack never sent, BUS_TIMEOUT=4 -> 4 BUSY cycles, then DONE with bus_err_o=1, wreg_o=0, then IDLE.
- rst during BUSY, then ack next cycle -> state IDLE, dbus_req_o=0, ack ignored, all outputs at reset values.
